// File: rtl/lcd_status_writer_if.sv
// Status-in / LCD-pins-out bundle for lcd_status_writer.
// master: the writer; slave: the status source and LCD side.
interface lcd_status_writer_if #(
  parameter int unsigned STATE_W = 3
);
  logic [STATE_W-1:0] status;
  logic               refresh;
  logic               rs;
  logic               rw;
  logic               en;
  logic [7:0]         data;
  logic               busy;
  logic               done;

  modport master (
    input  status, refresh,
    output rs, rw, en, data, busy, done
  );

  modport slave (
    output status, refresh,
    input  rs, rw, en, data, busy, done
  );
endinterface

// File: rtl/lcd_status_writer.sv
// HD44780 writer: power-up wait, init sequence, then one text message per status code.
// Define LCD_LINE2_EN to also write "CODE=<hex>" on line 2 after each message.
module lcd_status_writer #(
  parameter int unsigned POWERUP_DELAY = 750000,
  parameter int unsigned EN_PULSE      = 25,
  parameter int unsigned CMD_DELAY     = 2500,
  parameter int unsigned CLEAR_DELAY   = 100000,
  parameter int unsigned MSG_LEN       = 8,
  parameter int unsigned STATE_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  lcd_status_writer_if.master bus
);
  localparam int unsigned MAX_DLY  = (CLEAR_DELAY > CMD_DELAY) ? CLEAR_DELAY : CMD_DELAY;
  localparam int unsigned MAX_SLOT = 1 + EN_PULSE + MAX_DLY;
  localparam int unsigned MAX_CNT  = (POWERUP_DELAY > MAX_SLOT) ? POWERUP_DELAY : MAX_SLOT;
  localparam int unsigned CW       = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    StPwrup,
    StInit,
    StHome,
    StChar,
`ifdef LCD_LINE2_EN
    StLine2,
`endif
    StIdle
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic [STATE_W-1:0]   cur_q, cur_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 slot_rs;
  logic [7:0]           slot_data;
  logic [CW-1:0]        slot_end;
  logic                 slot_last;

  // Messages stored pre-padded with spaces; positions past 8 are blank.
  function automatic logic [7:0] msg_char(input logic [STATE_W-1:0] code, input logic [4:0] pos);
    logic [63:0] text;
    int unsigned c;
    c = 32'(code);
    case (c)
      0:       text = "IDLE    ";
      1:       text = "WASHING ";
      2:       text = "SPINNING";
      3:       text = "DRYING  ";
      4:       text = "DONE    ";
      default: text = "ERROR   ";
    endcase
    if (pos > 5'd7) return 8'h20;
    return text[{3'd7 - pos[2:0], 3'b000} +: 8];
  endfunction

`ifdef LCD_LINE2_EN
  // Slot 0 of line 2 is the 0xC0 address command; slots 1..6 spell "CODE=<hex>".
  function automatic logic [7:0] line2_char(input logic [STATE_W-1:0] code,
                                            input logic [4:0] pos);
    logic [63:0] tag;
    logic [3:0]  nib;
    tag = {24'h0, "CODE="};
    nib = 4'(code);
    if (pos == 5'd6) return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    return tag[{3'd5 - pos[2:0], 3'b000} +: 8];
  endfunction
`endif

  assign slot_end  = (!slot_rs && slot_data == 8'h01) ? CW'(EN_PULSE + CLEAR_DELAY)
                                                       : CW'(EN_PULSE + CMD_DELAY);
  assign slot_last = (cnt_q == slot_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    cur_d   = cur_q;
    pend_d  = pend_q | (bus.refresh & (state_q != StIdle));
    done_d  = 1'b0;
    case (state_q)
      StPwrup: begin
        if (cnt_q == CW'(POWERUP_DELAY - 1)) begin
          state_d = StInit;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StInit: begin
        if (slot_last) begin
          cnt_d = '0;
          if (idx_q == 5'd3) begin
            state_d = StHome;
            idx_d   = '0;
            cur_d   = bus.status;
            pend_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StHome: begin
        if (slot_last) begin
          state_d = StChar;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StChar: begin
        if (slot_last) begin
          cnt_d = '0;
          if (idx_q == 5'(MSG_LEN - 1)) begin
            idx_d = '0;
`ifdef LCD_LINE2_EN
            state_d = StLine2;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef LCD_LINE2_EN
      StLine2: begin
        if (slot_last) begin
          cnt_d = '0;
          if (idx_q == 5'd6) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`endif
      StIdle: begin
        cnt_d = '0;
        if (bus.status != cur_q || bus.refresh || pend_q) begin
          state_d = StHome;
          idx_d   = '0;
          cur_d   = bus.status;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
      end
    endcase
  end

  // data/rs are a pure function of state and slot index, so they hold for the whole slot.
  always_comb begin
    slot_rs   = 1'b0;
    slot_data = 8'h00;
    case (state_q)
      StInit: begin
        case (idx_q)
          5'd0:    slot_data = 8'h38;
          5'd1:    slot_data = 8'h0C;
          5'd2:    slot_data = 8'h01;
          default: slot_data = 8'h06;
        endcase
      end
      StHome:  slot_data = 8'h80;
      StChar: begin
        slot_rs   = 1'b1;
        slot_data = msg_char(cur_q, idx_q);
      end
`ifdef LCD_LINE2_EN
      StLine2: begin
        slot_rs   = (idx_q != 5'd0);
        slot_data = (idx_q == 5'd0) ? 8'hC0 : line2_char(cur_q, idx_q);
      end
`endif
      default: ;
    endcase
    bus.rs   = slot_rs;
    bus.data = slot_data;
    bus.rw   = 1'b0;
    bus.en   = (state_q != StPwrup) && (state_q != StIdle) &&
               (cnt_q != '0) && (cnt_q <= CW'(EN_PULSE));
    bus.busy = (state_q != StIdle);
    bus.done = done_q;
  end
endmodule

// File: tb/tb_lcd_status_writer.sv
// Randomised bench for lcd_status_writer: LCD writes are captured at each en rise and
// compared against message sequences built from the status-to-text table.
module tb_lcd_status_writer;
  localparam int P   = 10;
  localparam int EP  = 2;
  localparam int CD  = 4;
  localparam int CLD = 8;
  localparam int M   = 8;
  localparam int S   = 1 + EP + CD;
  localparam int C   = 1 + EP + CLD;
`ifdef LCD_LINE2_EN
  localparam int L2  = 7 * S;
`else
  localparam int L2  = 0;
`endif
  localparam int FIRST_DONE = P + 3 * S + C + (1 + M) * S + L2;
  // One trigger cycle in IDLE, then HOME + characters (+ line 2).
  localparam int REWRITE    = 1 + (1 + M) * S + L2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   shown;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  lcd_status_writer_if #(.STATE_W(3)) bus ();

  lcd_status_writer #(
    .POWERUP_DELAY(P),
    .EN_PULSE     (EP),
    .CMD_DELAY    (CD),
    .CLEAR_DELAY  (CLD),
    .MSG_LEN      (M),
    .STATE_W      (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: capture {rs,data} at each en rise, check setup and pulse width.
  logic       en_prev  = 1'b0;
  logic [8:0] bus_prev = '0;
  int         hi_cnt   = 0;
  always @(negedge clk) begin
    if (bus.en && !en_prev) begin
      got_q.push_back({bus.rs, bus.data});
      if (!reset) begin
        check_eq("setup", {23'h0, bus_prev}, {23'h0, bus.rs, bus.data});
        check_eq("rw", {31'h0, bus.rw}, 32'h0);
      end
    end
    if (!bus.en && en_prev && !reset) check_eq("en_width", hi_cnt, EP);
    hi_cnt   = bus.en ? hi_cnt + 1 : 0;
    en_prev  = bus.en;
    bus_prev = {bus.rs, bus.data};
  end

  function automatic string msg_text(input int s);
    case (s)
      0:       return "IDLE";
      1:       return "WASHING";
      2:       return "SPINNING";
      3:       return "DRYING";
      4:       return "DONE";
      default: return "ERROR";
    endcase
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_msg(input int s);
    string      t;
    logic [7:0] ch;
    t = msg_text(s);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < M; i++) begin
      ch = (i < t.len()) ? 8'(t[i]) : 8'h20;
      exp_q.push_back({1'b1, ch});
    end
`ifdef LCD_LINE2_EN
    t = "CODE=";
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 8'(t[i])});
    ch = ((s % 16) < 10) ? 8'(48 + s % 16) : 8'(55 + s % 16);
    exp_q.push_back({1'b1, ch});
`endif
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), {23'h0, got_q[i]}, {23'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < limit);
  endtask

  // Trigger from IDLE with (s, rf); optionally change status to s2 then s3 and pulse
  // refresh n_ref times while busy. A second message follows iff the final status differs
  // from the one latched or any refresh arrived while busy.
  task automatic rewrite(input string tag, input int s, input bit rf, input int mid_at,
                         input int s2, input int s3, input int n_ref);
    int lat;
    int lat2;
    bus.status  = 3'(s);
    bus.refresh = rf;
    @(negedge clk);
    bus.refresh = 1'b0;
    check_eq({tag, "_home"}, {31'h0, bus.busy}, 32'h1);
    lat = 1;
    while (!bus.done && lat < 4 * REWRITE) begin
      if (lat == mid_at) bus.status = 3'(s2);
      if (lat == mid_at + 6) bus.status = 3'(s3);
      bus.refresh = (n_ref > 0) && (lat >= mid_at) && (lat < mid_at + 2 * n_ref) &&
                    ((lat - mid_at) % 2 == 0);
      @(negedge clk);
      lat++;
    end
    bus.refresh = 1'b0;
    check_eq({tag, "_lat"}, lat, REWRITE);
    check_eq({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    push_msg(s);
    shown = s;
    if (s3 != s || n_ref > 0) begin
      wait_done(lat2, 4 * REWRITE);
      check_eq({tag, "_lat2"}, lat2, REWRITE);
      push_msg(s3);
      shown = s3;
    end
    repeat (30) @(negedge clk);
    check_eq({tag, "_idle"}, {31'h0, bus.busy}, 32'h0);
    compare_writes(tag);
  endtask

  task automatic random_phase(input int iters);
    int s;
    int s2;
    int s3;
    int mid;
    int nr;
    bit rf;
    for (int it = 0; it < iters; it++) begin
      s  = $urandom_range(0, 7);
      rf = 1'($urandom_range(0, 1));
      if (s == shown && !rf) begin
        bus.status = 3'(s);
        repeat (20) @(negedge clk);
        check_eq($sformatf("rnd%0d_quiet", it), {31'h0, bus.busy}, 32'h0);
        compare_writes($sformatf("rnd%0d", it));
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          mid = $urandom_range(2, 40);
          s2  = $urandom_range(0, 7);
          s3  = $urandom_range(0, 1) == 1 ? s : $urandom_range(0, 7);
          nr  = $urandom_range(0, 3);
        end else begin
          mid = 1000;
          s2  = s;
          s3  = s;
          nr  = 0;
        end
        rewrite($sformatf("rnd%0d", it), s, rf, mid, s2, s3, nr);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset       = 1'b1;
    bus.status  = 3'd0;
    bus.refresh = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rs", {31'h0, bus.rs}, 32'h0);
    check_eq("rst_rw", {31'h0, bus.rw}, 32'h0);
    check_eq("rst_en", {31'h0, bus.en}, 32'h0);
    check_eq("rst_data", {24'h0, bus.data}, 32'h0);
    check_eq("rst_busy", {31'h0, bus.busy}, 32'h1);
    check_eq("rst_done", {31'h0, bus.done}, 32'h0);

    reset = 1'b0;
    wait_done(n, 4 * FIRST_DONE);
    check_eq("first_done", n, FIRST_DONE);
    check_eq("first_busy", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    check_eq("done_pulse", {31'h0, bus.done}, 32'h0);
    push_init();
    push_msg(0);
    shown = 0;
    compare_writes("init");

    rewrite("st01", 1, 1'b0, 1000, 1, 1, 0);
    rewrite("mid", 1, 1'b1, 20, 2, 3, 0);
    rewrite("ref3", 3, 1'b1, 10, 3, 3, 3);
    rewrite("err", 6, 1'b0, 1000, 6, 6, 0);

    random_phase(25);

    // Reset while the clear command strobe is high, then a full restart.
    bus.status = 3'd2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    reset = 1'b0;
    n = 0;
    while (!(bus.en && !bus.rs && bus.data == 8'h01) && n < 4 * FIRST_DONE) begin
      @(negedge clk);
      n++;
    end
    check_eq("clr_found", {23'h0, bus.en, bus.data}, {23'h0, 1'b1, 8'h01});
    reset = 1'b1;
    #1;
    check_eq("arst_en", {31'h0, bus.en}, 32'h0);
    check_eq("arst_data", {24'h0, bus.data}, 32'h0);
    check_eq("arst_busy", {31'h0, bus.busy}, 32'h1);
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    reset = 1'b0;
    wait_done(n, 4 * FIRST_DONE);
    check_eq("restart_done", n, FIRST_DONE);
    push_init();
    push_msg(2);
    shown = 2;
    repeat (20) @(negedge clk);
    compare_writes("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
